pong_score_keeper: RTL and testbench
====================================

Name: pong_score_keeper

Overview:
- Tracks both players' Pong scores as two-digit BCD.
- Consumes point events from the ball/collision logic.
- Feeds the four digits directly to the seven-segment display driver (first_1/first_0 for player 1, second_1/second_0 for player 2).
- Sequences the rally: freezes play for a hold period after each point, decides the serve direction, and latches a winner at the target score.

Parameters:
- WIN_SCORE, 11, points needed to win. Legal range 1..99.
- HOLD_CYCLES, 25000000, clk cycles play stays frozen after a point (1 s at 25 MHz). Must be >= 1.
- HOLD_W, 25, width of the hold counter. Must satisfy 2^HOLD_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high. Clears all state.
- point_p1  in  1  level from ball logic: ball passed player 2's paddle. May stay high many cycles.
- point_p2  in  1  level from ball logic: ball passed player 1's paddle.
- game_restart  in  1  synchronous request to start a new game.
- first_1  out  4  player 1 tens digit, BCD.
- first_0  out  4  player 1 ones digit, BCD.
- second_1  out  4  player 2 tens digit, BCD.
- second_0  out  4  player 2 ones digit, BCD.
- freeze  out  1  high while ball/paddles must be held (HOLD, OVER).
- serve_left  out  1  1 = next serve travels toward player 1, 0 = toward player 2.
- game_over  out  1  high in OVER.
- winner  out  2  00 none, 01 player 1, 10 player 2. 11 never driven.

Behaviour:
- Reset (async assert):
  - all digits 0, state HOLD, hold counter 0, freeze=1, serve_left=0, game_over=0, winner=00.
  - Edge-detect registers cleared to 0.
- Edge detection:
  - point_p1_d and point_p2_d register the previous-cycle inputs.
  - rise1 = point_p1 & ~point_p1_d; rise2 likewise.
  - Only rises count. A held-high input scores once.
- State machine, states PLAY, HOLD, OVER:
  - PLAY, exactly one rise: score that player (visible on outputs after that edge).
    - New score == WIN_SCORE: go to OVER, set game_over=1, winner=01 or 10.
    - Otherwise: go to HOLD, hold counter=0, serve_left=1 if player 2 scored (serve toward the loser), 0 if player 1 scored.
  - PLAY, rise1 & rise2 in the same cycle: no score, stay in PLAY (treated as glitch).
  - HOLD:
    - Rises ignored.
    - Counter increments each cycle.
    - When counter == HOLD_CYCLES-1: next state PLAY, counter to 0. HOLD therefore lasts exactly HOLD_CYCLES cycles.
  - OVER: rises ignored, digits frozen, stays until game_restart or reset.
  - game_restart high in any state (priority over point events): digits 0, winner=00, game_over=0, state HOLD, counter 0, serve_left unchanged.
- Outputs: freeze = (state != PLAY). All outputs are registered; none are combinational from inputs.
- BCD increment:
  - ones < 9: ones+1.
  - ones == 9: ones=0, tens+1.
  - Tens never exceeds 9 because WIN_SCORE <= 99 stops play first.
- Win compare: against WIN_SCORE converted to BCD at elaboration (tens = WIN_SCORE/10, ones = WIN_SCORE%10).
- Digits are always valid BCD (0..9). The display's out-of-range default glyph must never appear.
- Reset asserted mid-HOLD or in OVER: immediate return to reset values; no partial counts survive.

Test Plan (HOLD_CYCLES=4, WIN_SCORE=11 unless noted):
1. Reset released -> all digits 0, freeze=1 for 4 cycles, then freeze=0 (PLAY), winner=00.
2. In PLAY, point_p1 high for 10 cycles -> first_0=1 after the first edge only, freeze=1 for exactly 4 cycles, serve_left=0. A second point_p1 pulse during HOLD -> no change.
3. Nine player-2 points, then a tenth -> second_1=1, second_0=0 (carry 9->10). Player 2 points 11 -> game_over=1, winner=10, freeze=1. Further point_p1/point_p2 pulses -> digits unchanged.
4. Same-cycle rise on point_p1 and point_p2 in PLAY -> no score change, freeze stays 0.
5. In OVER, pulse game_restart -> digits 0, winner=00, game_over=0, freeze=1 for 4 cycles, then PLAY. Restart coincident with a point rise -> restart wins, scores 0.
6. Assert reset mid-HOLD at score 3-5 -> outputs immediately 0/0, winner=00, freeze=1. WIN_SCORE=1 run -> first point goes straight to OVER, winner set.

Source files
------------

// File: rtl/pong_score_keeper.sv
// Two-player Pong score keeper: BCD score digits, post-point hold timer,
// serve direction and winner latch for the seven-segment display path.
module pong_score_keeper #(
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned HOLD_W      = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       game_restart,
  output logic [3:0] first_1,
  output logic [3:0] first_0,
  output logic [3:0] second_1,
  output logic [3:0] second_0,
  output logic       freeze,
  output logic       serve_left,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [7:0]        WIN_BCD   = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

  state_t            state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic              point_p1_d, point_p2_d;
  logic              rise1, rise2;
  logic [7:0]        p1_bcd, p2_bcd, p1_bcd_n, p2_bcd_n, p1_inc, p2_inc;
  logic              serve_left_n, game_over_n;
  logic [1:0]        winner_n;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign rise1  = point_p1 & ~point_p1_d;
  assign rise2  = point_p2 & ~point_p2_d;
  assign p1_inc = bcd_inc(p1_bcd);
  assign p2_inc = bcd_inc(p2_bcd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      point_p1_d <= 1'b0;
      point_p2_d <= 1'b0;
      p1_bcd     <= '0;
      p2_bcd     <= '0;
      serve_left <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 2'b00;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_cnt_n;
      point_p1_d <= point_p1;
      point_p2_d <= point_p2;
      p1_bcd     <= p1_bcd_n;
      p2_bcd     <= p2_bcd_n;
      serve_left <= serve_left_n;
      game_over  <= game_over_n;
      winner     <= winner_n;
    end
  end

  always_comb begin
    state_n      = state;
    hold_cnt_n   = hold_cnt;
    p1_bcd_n     = p1_bcd;
    p2_bcd_n     = p2_bcd;
    serve_left_n = serve_left;
    game_over_n  = game_over;
    winner_n     = winner;
    if (game_restart) begin
      state_n     = HOLD;
      hold_cnt_n  = '0;
      p1_bcd_n    = '0;
      p2_bcd_n    = '0;
      game_over_n = 1'b0;
      winner_n    = 2'b00;
    end else begin
      unique case (state)
        PLAY: begin
          // simultaneous rises are treated as a glitch and ignored
          if (rise1 && !rise2) begin
            p1_bcd_n = p1_inc;
            if (p1_inc == WIN_BCD) begin
              state_n     = OVER;
              game_over_n = 1'b1;
              winner_n    = 2'b01;
            end else begin
              state_n      = HOLD;
              hold_cnt_n   = '0;
              serve_left_n = 1'b0;
            end
          end else if (rise2 && !rise1) begin
            p2_bcd_n = p2_inc;
            if (p2_inc == WIN_BCD) begin
              state_n     = OVER;
              game_over_n = 1'b1;
              winner_n    = 2'b10;
            end else begin
              state_n      = HOLD;
              hold_cnt_n   = '0;
              serve_left_n = 1'b1;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_n    = PLAY;
            hold_cnt_n = '0;
          end else begin
            hold_cnt_n = hold_cnt + 1'b1;
          end
        end
        OVER: ;
        default: state_n = HOLD;
      endcase
    end
  end

  assign freeze   = (state != PLAY);
  assign first_1  = p1_bcd[7:4];
  assign first_0  = p1_bcd[3:0];
  assign second_1 = p2_bcd[7:4];
  assign second_0 = p2_bcd[3:0];

endmodule

// File: tb/tb_pong_score_keeper.sv
// Randomised and directed bench for pong_score_keeper against an integer
// score/timer model; a second instance covers the one-point game.
module tb_pong_score_keeper;

  localparam int HOLD = 4;
  localparam int WIN  = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic       point_p1, point_p2, game_restart;
  logic [3:0] first_1, first_0, second_1, second_0;
  logic       freeze, serve_left, game_over;
  logic [1:0] winner;

  logic       b_p1, b_p2, b_restart;
  logic [3:0] b_f1, b_f0, b_s1, b_s0;
  logic       b_freeze, b_serve, b_over;
  logic [1:0] b_winner;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_s1, m_s2, m_hold_left, m_winner;
  bit m_over, m_serve, m_prev1, m_prev2;

  always #5 clk = ~clk;

  pong_score_keeper #(.WIN_SCORE(WIN), .HOLD_CYCLES(HOLD), .HOLD_W(3)) dut (
    .clk(clk), .reset(reset), .point_p1(point_p1), .point_p2(point_p2),
    .game_restart(game_restart), .first_1(first_1), .first_0(first_0),
    .second_1(second_1), .second_0(second_0), .freeze(freeze),
    .serve_left(serve_left), .game_over(game_over), .winner(winner)
  );

  pong_score_keeper #(.WIN_SCORE(1), .HOLD_CYCLES(HOLD), .HOLD_W(3)) dut_w1 (
    .clk(clk), .reset(reset), .point_p1(b_p1), .point_p2(b_p2),
    .game_restart(b_restart), .first_1(b_f1), .first_0(b_f0),
    .second_1(b_s1), .second_0(b_s0), .freeze(b_freeze),
    .serve_left(b_serve), .game_over(b_over), .winner(b_winner)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_hold_left = HOLD; m_winner = 0;
    m_over = 0; m_serve = 0; m_prev1 = 0; m_prev2 = 0;
  endtask

  task automatic model_step(input bit p1, input bit p2, input bit rs);
    bit r1, r2;
    r1 = p1 && !m_prev1;
    r2 = p2 && !m_prev2;
    m_prev1 = p1;
    m_prev2 = p2;
    if (rs) begin
      m_s1 = 0; m_s2 = 0; m_winner = 0; m_over = 0; m_hold_left = HOLD;
    end else if (m_over) begin
    end else if (m_hold_left > 0) begin
      m_hold_left--;
    end else if (r1 != r2) begin
      if (r1) m_s1++; else m_s2++;
      if (m_s1 == WIN || m_s2 == WIN) begin
        m_over = 1;
        m_winner = r1 ? 1 : 2;
      end else begin
        m_hold_left = HOLD;
        m_serve = r2;
      end
    end
  endtask

  task automatic check_all();
    chk("first_1",    8'(first_1),    8'(m_s1 / 10));
    chk("first_0",    8'(first_0),    8'(m_s1 % 10));
    chk("second_1",   8'(second_1),   8'(m_s2 / 10));
    chk("second_0",   8'(second_0),   8'(m_s2 % 10));
    chk("freeze",     8'(freeze),     8'(m_over || m_hold_left > 0));
    chk("serve_left", 8'(serve_left), 8'(m_serve));
    chk("game_over",  8'(game_over),  8'(m_over));
    chk("winner",     8'(winner),     8'(m_winner));
  endtask

  task automatic step(input bit p1, input bit p2, input bit rs);
    point_p1 = p1;
    point_p2 = p2;
    game_restart = rs;
    @(posedge clk);
    model_step(p1, p2, rs);
    #1;
    check_all();
  endtask

  task automatic point(input int who);
    step(who == 1, who == 2, 1'b0);
    repeat (HOLD + 1) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    point_p1 = 1'b0; point_p2 = 1'b0; game_restart = 1'b0;
    b_p1 = 1'b0; b_p2 = 1'b0; b_restart = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    point_p1 = 1'b0; point_p2 = 1'b0; game_restart = 1'b0;
    b_p1 = 1'b0; b_p2 = 1'b0; b_restart = 1'b0;
    reset = 1'b0;
    #2;
    do_reset();

    // reset release: frozen for HOLD cycles, then play
    repeat (HOLD + 1) step(1'b0, 1'b0, 1'b0);
    chk("play_after_reset", 8'(freeze), 8'd0);

    // one-point game on the second instance
    b_p1 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    b_p1 = 1'b0;
    chk("w1_first_0", 8'(b_f0),     8'd1);
    chk("w1_over",    8'(b_over),   8'd1);
    chk("w1_winner",  8'(b_winner), 8'd1);
    chk("w1_freeze",  8'(b_freeze), 8'd1);

    // held-high point scores once; then pulse during hold is ignored
    repeat (10) step(1'b1, 1'b0, 1'b0);
    chk("held_p1_once", 8'(first_0), 8'd1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (HOLD) step(1'b0, 1'b0, 1'b0);
    chk("serve_to_loser", 8'(serve_left), 8'd1);

    // simultaneous rises are a glitch
    step(1'b1, 1'b1, 1'b0);
    chk("glitch_freeze", 8'(freeze), 8'd0);
    step(1'b0, 1'b0, 1'b0);

    // player 2 through the 9->10 carry and on to the win
    while (m_s2 < 10) point(2);
    chk("carry_tens", 8'(second_1), 8'd1);
    chk("carry_ones", 8'(second_0), 8'd0);
    point(2);
    chk("p2_wins", 8'(winner), 8'd2);
    point(1);
    point(2);

    // restart from OVER, then restart coincident with a rise
    step(1'b0, 1'b0, 1'b1);
    repeat (HOLD) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("restart_priority", 8'(first_0), 8'd0);
    repeat (HOLD + 1) step(1'b0, 1'b0, 1'b0);

    // reset mid-hold at 3-5
    while (m_s1 < 3) point(1);
    while (m_s2 < 4) point(2);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2;
    do_reset();

    // randomised play with occasional restarts
    for (int i = 0; i < 1500; i++)
      step(($urandom % 5) == 0, ($urandom % 5) == 0, ($urandom % 120) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
